// File: rtl/nat_arith_unit.sv
// nat_arith_unit: registered unsigned add-with-carry or x*y[M-1:0]+c, one result per cycle.
// Both datapaths share one ripple-carry adder function; mul-add is an M-row shift-and-add array.
module nat_arith_unit #(
    parameter int N = 8,
    parameter int M = 2
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic           in_valid,
    input  logic           op,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic [N-1:0]   c,
    input  logic           c_in,
    output logic           out_valid,
    output logic [N+M-1:0] result,
    output logic           c_out
);
    function automatic logic [N:0] rca(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        logic [N-1:0] s;
        logic cy;
        s = '0;
        cy = ci;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        return {cy, s};
    endfunction

    logic [N:0]     add_sum;
    logic [N-1:0]   acc [0:M];
    logic [M-1:0]   lo;
    logic [N+M-1:0] mul_res;

    assign add_sum = rca(x, y, c_in);

    // c seeds the running partial sum, so the addend costs no extra adder row
    assign acc[0] = c;
    for (genvar j = 0; j < M; j++) begin : g_row
        logic [N:0] row;
        assign row        = rca(acc[j], y[j] ? x : '0, 1'b0);
        assign lo[j]      = row[0];
        assign acc[j + 1] = N'(row >> 1);
    end
    assign mul_res = {acc[M], lo};

    logic           out_valid_d, out_valid_q;
    logic [N+M-1:0] result_d, result_q;
    logic           c_out_d, c_out_q;

    always_comb begin
        out_valid_d = in_valid;
        result_d    = !in_valid ? result_q : op ? mul_res : {{M{1'b0}}, add_sum[N-1:0]};
        c_out_d     = !in_valid ? c_out_q : !op & add_sum[N];
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            c_out_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            c_out_q     <= c_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign c_out     = c_out_q;
endmodule

// File: tb/tb_nat_arith_unit.sv
// tb_nat_arith_unit: directed vectors on three parameterisations (8/2, 10/3, 13/2) sharing one clock.
module tb_nat_arith_unit;
    logic clock = 1'b0;
    logic reset_ = 1'b0;
    logic in_valid = 1'b0;
    logic op = 1'b0;
    logic c_in = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0, c8 = '0;
    logic [9:0]  x10 = '0, y10 = '0, c10 = '0;
    logic [12:0] x13 = '0, y13 = '0, c13 = '0;
    logic [9:0]  r8;
    logic [12:0] r10;
    logic [14:0] r13;
    logic v8, v10, v13, co8, co10, co13;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    nat_arith_unit #(.N(8), .M(2)) u8 (
        .clock(clock), .reset_(reset_), .in_valid(in_valid), .op(op), .x(x8), .y(y8), .c(c8),
        .c_in(c_in), .out_valid(v8), .result(r8), .c_out(co8));
    nat_arith_unit #(.N(10), .M(3)) u10 (
        .clock(clock), .reset_(reset_), .in_valid(in_valid), .op(op), .x(x10), .y(y10), .c(c10),
        .c_in(c_in), .out_valid(v10), .result(r10), .c_out(co10));
    nat_arith_unit #(.N(13), .M(2)) u13 (
        .clock(clock), .reset_(reset_), .in_valid(in_valid), .op(op), .x(x13), .y(y13), .c(c13),
        .c_in(c_in), .out_valid(v13), .result(r13), .c_out(co13));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] cc, input logic ci);
        in_valid = iv;
        op = o;
        c_in = ci;
        x8 = a[7:0];   y8 = b[7:0];   c8 = cc[7:0];
        x10 = a[9:0];  y10 = b[9:0];  c10 = cc[9:0];
        x13 = a[12:0]; y13 = b[12:0]; c13 = cc[12:0];
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        step();
        step();
        chk("rst_v8", {31'b0, v8}, 0);
        chk("rst_r8", {22'b0, r8}, 0);
        chk("rst_co8", {31'b0, co8}, 0);
        reset_ = 1'b1;

        drive(1, 1, 255, 3, 0, 0);
        step();
        chk("mul8_r", {22'b0, r8}, 765);
        chk("mul8_co", {31'b0, co8}, 0);
        chk("mul8_v", {31'b0, v8}, 1);
        chk("mul10_r", {19'b0, r10}, 765);

        drive(1, 0, 255, 765, 0, 0);
        step();
        chk("add10_r", {19'b0, r10}, 1020);
        chk("add10_co", {31'b0, co10}, 0);
        chk("add8_r", {22'b0, r8}, 252);
        chk("add8_co", {31'b0, co8}, 1);
        chk("b2b_v10", {31'b0, v10}, 1);

        drive(1, 1, 1020, 5, 0, 0);
        step();
        chk("mul10_5100", {19'b0, r10}, 5100);
        chk("mul13_y1", {17'b0, r13}, 1020);

        drive(1, 0, 5100, 255, 0, 0);
        step();
        chk("add13_r", {17'b0, r13}, 5355);
        chk("add13_co", {31'b0, co13}, 0);

        drive(1, 1, 255, 3, 255, 1);
        step();
        chk("mul8_max", {22'b0, r8}, 1020);
        chk("mul8_max_co", {31'b0, co8}, 0);

        drive(1, 0, 255, 0, 255, 1);
        step();
        chk("wrap8_r", {22'b0, r8}, 0);
        chk("wrap8_co", {31'b0, co8}, 1);

        drive(1, 0, 200, 100, 0, 1);
        step();
        chk("add8_cin_r", {22'b0, r8}, 45);
        chk("add8_cin_co", {31'b0, co8}, 1);

        drive(0, 0, 7, 7, 7, 0);
        step();
        chk("idle_v8", {31'b0, v8}, 0);
        chk("idle_r8", {22'b0, r8}, 45);
        chk("idle_co8", {31'b0, co8}, 1);

        drive(1, 0, 1, 1, 0, 0);
        step();
        chk("pre_rst_r8", {22'b0, r8}, 2);
        #2 reset_ = 1'b0;
        #1;
        chk("async_v8", {31'b0, v8}, 0);
        chk("async_r8", {22'b0, r8}, 0);
        chk("async_co8", {31'b0, co8}, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        reset_ = 1'b1;
        step();
        chk("post_rst_v8", {31'b0, v8}, 0);
        chk("post_rst_r8", {22'b0, r8}, 0);

        drive(1, 0, 3, 4, 0, 0);
        step();
        chk("first_r8", {22'b0, r8}, 7);
        chk("first_v8", {31'b0, v8}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/nat_arith_unit.md
NAT_ARITH_UNIT -- requirements
Module: nat_arith_unit

Interface
REQ-001 Parameter N, default 8, operand width of x, y and c; N >= 1.
REQ-002 Parameter M, default 2, multiplier width used by the mul-add operation; 1 <= M <= N.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set is presented this cycle.
REQ-006 op  input  1  operation select: 0 = add, 1 = mul-add.
REQ-007 x  input  N  first natural operand.
REQ-008 y  input  N  second operand; add uses all N bits, mul-add uses y[M-1:0] only.
REQ-009 c  input  N  addend for mul-add; ignored by add.
REQ-010 c_in  input  1  carry-in for add; ignored by mul-add.
REQ-011 out_valid  output  1  result and c_out hold a newly computed value.
REQ-012 result  output  N+M  registered arithmetic result.
REQ-013 c_out  output  1  registered carry-out of add; 0 after a mul-add.

Function
REQ-014 All operands SHALL be unsigned naturals; no signed interpretation anywhere.
REQ-015 Add: s = (x + y + c_in) mod 2^N; carry = bit N of the full sum; result SHALL be s zero-extended to N+M bits, with c_out = carry.
REQ-016 Mul-add: result SHALL be x * y[M-1:0] + c, computed exactly in N+M bits, with c_out = 0.
REQ-017 The mul-add result never overflows, since (2^N-1)(2^M-1) + 2^N-1 < 2^(N+M); no saturation or overflow flag SHALL exist.
REQ-018 The datapath SHALL be combinational from inputs to the output registers: an N-bit ripple-carry adder block and an N-by-M shift-and-add array built from that adder, with the c addend injected into the first partial-sum row.
REQ-019 Latency SHALL be exactly 1 cycle: operands sampled at edge k with in_valid=1 appear on result and c_out, with out_valid=1, after edge k.
REQ-020 Back-to-back in_valid=1 on consecutive cycles SHALL yield one result per cycle; there is no backpressure.
REQ-021 At an edge with in_valid=0, out_valid SHALL go to 0, and result and c_out SHALL hold their previous values.
REQ-022 The unit SHALL carry no other state; consecutive operations are independent.

Reset
REQ-023 While reset_=0, out_valid=0, result=0 and c_out=0, applied immediately without waiting for a clock edge.
REQ-024 If reset_ is asserted while an operation is in flight, that operation SHALL be discarded, with no out_valid pulse after release.
REQ-025 The first edge with reset_=1 SHALL sample inputs normally.

Verification
REQ-026 N=8, M=2, op=1, x=255, y=3, c=0 -> one cycle later result=765, c_out=0, out_valid=1.
REQ-027 N=10, op=0, x=255, y=765, c_in=0 -> result=1020, c_out=0; then N=10, M=3, op=1, x=1020, y=5, c=0 -> result=5100.
REQ-028 N=13, op=0, x=5100, y=255, c_in=0 -> result=5355; equals 5*(a+3b)+c for a=b=c=255.
REQ-029 N=8, op=0, x=255, y=0, c_in=1 -> result=0, c_out=1 (wrap-around); N=8, M=2, op=1, x=255, y=3, c=255 -> result=1020 (maximum, no overflow).
REQ-030 Two back-to-back in_valid cycles -> two consecutive out_valid cycles with the matching results; in_valid=0 on the next cycle -> out_valid=0 with result held.
REQ-031 Assert reset_=0 mid-cycle after an in_valid sample -> outputs cleared before the next edge, and no out_valid after release.
